// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: definitions shared by the execute stage, the M-extension core
// and its sequencing controller.
//   alum_exe_type  : M-extension command encoding (ALUM_X = no operation)
//   DIV0_QUOT      : quotient returned for a divide by zero
//   INT_MIN        : most negative 32-bit integer
//   is_mul_op      : command belongs to the multiply family
//   is_signed_op   : command treats at least one operand as signed
//   abs32          : two's-complement magnitude (|INT_MIN| wraps to INT_MIN)
package muldiv_ctrl_pkg;

  typedef enum logic [3:0] {
    ALUM_X      = 4'd0,
    ALUM_MUL    = 4'd1,
    ALUM_MULH   = 4'd2,
    ALUM_MULHU  = 4'd3,
    ALUM_MULHSU = 4'd4,
    ALUM_DIV    = 4'd5,
    ALUM_DIVU   = 4'd6,
    ALUM_REM    = 4'd7,
    ALUM_REMU   = 4'd8
  } alum_exe_type;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  function automatic logic is_mul_op(input alum_exe_type cmd);
    return (cmd == ALUM_MUL) || (cmd == ALUM_MULH) ||
           (cmd == ALUM_MULHU) || (cmd == ALUM_MULHSU);
  endfunction

  function automatic logic is_signed_op(input alum_exe_type cmd);
    return (cmd == ALUM_MULH) || (cmd == ALUM_MULHSU) ||
           (cmd == ALUM_DIV) || (cmd == ALUM_REM);
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: request/response channel between the execute stage and the
// multiply/divide controller.
//   in_valid/in_ready/in_cmd/in_a/in_b : op request (execute -> controller)
//   out_valid/out_ready/out_data       : result (controller -> writeback)
//   modport master : execute-stage side
//   modport slave  : controller side
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic         in_valid;
  logic         in_ready;
  alum_exe_type in_cmd;
  logic [31:0]  in_a;
  logic [31:0]  in_b;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;

  modport master (
    output in_valid, in_cmd, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_cmd, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational sign handling around the unsigned core.
//   cmd_i, a_i, b_i      : op as presented by the execute stage
//   core_cmd_o/a_o/b_o   : first-pass unsigned core command and operands
//   neg_o                : final result must be negated
//   two_pass_o           : negated multiply-high needs MUL then MULHU
//   special_o/_data_o    : op resolved without the core, and its result
//   neg_i, lo_i, res_i   : stored sign, stored low word, core result
//   single_o             : single-pass result with sign applied
//   combined_o           : two-pass negated high word
module muldiv_signfix
  import muldiv_ctrl_pkg::*;
(
  input  alum_exe_type cmd_i,
  input  logic [31:0]  a_i,
  input  logic [31:0]  b_i,
  output alum_exe_type core_cmd_o,
  output logic [31:0]  core_a_o,
  output logic [31:0]  core_b_o,
  output logic         neg_o,
  output logic         two_pass_o,
  output logic         special_o,
  output logic [31:0]  special_data_o,
  input  logic         neg_i,
  input  logic [31:0]  lo_i,
  input  logic [31:0]  res_i,
  output logic [31:0]  single_o,
  output logic [31:0]  combined_o
);

  logic div_op;
  logic rem_op;

  always_comb begin
    core_cmd_o = cmd_i;
    core_a_o   = a_i;
    core_b_o   = b_i;
    neg_o      = 1'b0;
    case (cmd_i)
      ALUM_MULH: begin
        core_cmd_o = ALUM_MULHU;
        core_a_o   = abs32(a_i);
        core_b_o   = abs32(b_i);
        neg_o      = a_i[31] ^ b_i[31];
      end
      ALUM_MULHSU: begin
        core_cmd_o = ALUM_MULHU;
        core_a_o   = abs32(a_i);
        neg_o      = a_i[31];
      end
      ALUM_DIV: begin
        core_cmd_o = ALUM_DIVU;
        core_a_o   = abs32(a_i);
        core_b_o   = abs32(b_i);
        neg_o      = a_i[31] ^ b_i[31];
      end
      ALUM_REM: begin
        core_cmd_o = ALUM_REMU;
        core_a_o   = abs32(a_i);
        core_b_o   = abs32(b_i);
        neg_o      = a_i[31];
      end
      default: ;
    endcase
    // Negating a 64-bit product needs the low word to know the carry into the
    // high word, so the first pass fetches the low half.
    two_pass_o = is_mul_op(cmd_i) && neg_o;
    if (two_pass_o) core_cmd_o = ALUM_MUL;
  end

  always_comb begin
    div_op         = (cmd_i == ALUM_DIV) || (cmd_i == ALUM_DIVU);
    rem_op         = (cmd_i == ALUM_REM) || (cmd_i == ALUM_REMU);
    special_o      = 1'b0;
    special_data_o = 32'd0;
    if ((div_op || rem_op) && (b_i == 32'd0)) begin
      special_o      = 1'b1;
      special_data_o = div_op ? DIV0_QUOT : a_i;
    end else if (is_signed_op(cmd_i) && !is_mul_op(cmd_i) &&
                 (a_i == INT_MIN) && (b_i == 32'hFFFF_FFFF)) begin
      special_o      = 1'b1;
      special_data_o = div_op ? INT_MIN : 32'd0;
    end
  end

  // -P = ~P + 1 over 64 bits: the +1 only carries into the high word when lo==0.
  assign single_o   = neg_i ? (~res_i + 32'd1) : res_i;
  assign combined_o = ~res_i + {31'd0, (lo_i == 32'd0)};

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences signed/unsigned RV32M ops onto an unsigned iterative
// core, resolving divide-by-zero and overflow locally.
//   clk, reset         : clock, asynchronous active-high reset
//   kill               : pipeline flush, cancels the in-flight op
//   exe (slave)        : op request / result channel to the execute stage
//   core_req_valid/ready, core_cmd, core_a, core_b : request to the core
//   core_kill          : one-cycle cancel pulse to the core
//   core_res_valid, core_c : core result strobe and value
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         kill,
  muldiv_ctrl_if.slave exe,
  output logic         core_req_valid,
  input  logic         core_req_ready,
  output alum_exe_type core_cmd,
  output logic [31:0]  core_a,
  output logic [31:0]  core_b,
  output logic         core_kill,
  input  logic         core_res_valid,
  input  logic [31:0]  core_c
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, ISSUE2, WAIT2, DONE
  } state_t;

  state_t       state_q, state_d;
  logic         in_ready_q, out_valid_q, core_req_valid_q, core_kill_q;
  logic         core_kill_d;
  logic [31:0]  out_data_q, out_data_d;
  alum_exe_type core_cmd_q, core_cmd_d;
  logic [31:0]  core_a_q, core_a_d, core_b_q, core_b_d;
  logic         neg_q, neg_d, two_pass_q, two_pass_d;
  logic [31:0]  lo_q, lo_d;

  alum_exe_type map_cmd;
  logic [31:0]  map_a, map_b, special_data, single_res, combined_res;
  logic         map_neg, map_two_pass, special;
  logic         accept;

  muldiv_signfix u_signfix (
    .cmd_i          (exe.in_cmd),
    .a_i            (exe.in_a),
    .b_i            (exe.in_b),
    .core_cmd_o     (map_cmd),
    .core_a_o       (map_a),
    .core_b_o       (map_b),
    .neg_o          (map_neg),
    .two_pass_o     (map_two_pass),
    .special_o      (special),
    .special_data_o (special_data),
    .neg_i          (neg_q),
    .lo_i           (lo_q),
    .res_i          (core_c),
    .single_o       (single_res),
    .combined_o     (combined_res)
  );

  assign accept = exe.in_valid && in_ready_q && (exe.in_cmd != ALUM_X) && !kill;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    core_cmd_d  = core_cmd_q;
    core_a_d    = core_a_q;
    core_b_d    = core_b_q;
    neg_d       = neg_q;
    two_pass_d  = two_pass_q;
    lo_d        = lo_q;
    core_kill_d = 1'b0;
    if (kill) begin
      state_d     = IDLE;
      core_kill_d = (state_q == ISSUE) || (state_q == WAIT) ||
                    (state_q == ISSUE2) || (state_q == WAIT2);
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (special) begin
              state_d    = DONE;
              out_data_d = special_data;
            end else begin
              state_d    = ISSUE;
              core_cmd_d = map_cmd;
              core_a_d   = map_a;
              core_b_d   = map_b;
              neg_d      = map_neg;
              two_pass_d = map_two_pass;
            end
          end
        end
        ISSUE:  if (core_req_ready) state_d = WAIT;
        WAIT: begin
          if (core_res_valid) begin
            if (two_pass_q) begin
              state_d    = ISSUE2;
              lo_d       = core_c;
              core_cmd_d = ALUM_MULHU;
            end else begin
              state_d    = DONE;
              out_data_d = single_res;
            end
          end
        end
        ISSUE2: if (core_req_ready) state_d = WAIT2;
        WAIT2: begin
          if (core_res_valid) begin
            state_d    = DONE;
            out_data_d = combined_res;
          end
        end
        DONE:    if (exe.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs are registered copies of the next-state decode so they
  // line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      in_ready_q       <= 1'b1;
      out_valid_q      <= 1'b0;
      core_req_valid_q <= 1'b0;
      core_kill_q      <= 1'b0;
      out_data_q       <= 32'd0;
      core_cmd_q       <= ALUM_X;
      core_a_q         <= 32'd0;
      core_b_q         <= 32'd0;
      neg_q            <= 1'b0;
      two_pass_q       <= 1'b0;
      lo_q             <= 32'd0;
    end else begin
      state_q          <= state_d;
      in_ready_q       <= (state_d == IDLE);
      out_valid_q      <= (state_d == DONE);
      core_req_valid_q <= (state_d == ISSUE) || (state_d == ISSUE2);
      core_kill_q      <= core_kill_d;
      out_data_q       <= out_data_d;
      core_cmd_q       <= core_cmd_d;
      core_a_q         <= core_a_d;
      core_b_q         <= core_b_d;
      neg_q            <= neg_d;
      two_pass_q       <= two_pass_d;
      lo_q             <= lo_d;
    end
  end

  assign exe.in_ready   = in_ready_q;
  assign exe.out_valid  = out_valid_q;
  assign exe.out_data   = out_data_q;
  assign core_req_valid = core_req_valid_q;
  assign core_cmd       = core_cmd_q;
  assign core_a         = core_a_q;
  assign core_b         = core_b_q;
  assign core_kill      = core_kill_q;

endmodule
